// File: rtl/pc_control_unit.sv
// pc_control_unit: RV32 fetch-stage program counter with sequential, branch and jump next-PC selection.

module sequential_unit (
  input  logic [31:0] i_pc,
  output logic [31:0] o_pc_seq
);
  assign o_pc_seq = i_pc + 32'd4;
endmodule

module branch_unit (
  input  logic [31:0] i_pc,
  input  logic [12:0] i_imm,
  input  logic [2:0]  i_func3,
  input  logic        i_enable,
  input  logic        i_z,
  input  logic        i_n,
  input  logic        i_v,
  input  logic        i_c,
  output logic        o_taken,
  output logic [31:0] o_target
);
  logic w_cond;
  // funct3[0] inverts the base condition of each pair (EQ/NE, LT/GE, LTU/GEU)
  assign w_cond = (i_func3[2:1] == 2'b00) ? (i_z ^ i_func3[0]) :
                  (i_func3[2:1] == 2'b10) ? ((i_n ^ i_v) ^ i_func3[0]) :
                  (i_func3[2:1] == 2'b11) ? (~i_c ^ i_func3[0]) : 1'b0;
  assign o_taken  = i_enable & w_cond;
  assign o_target = i_pc + {{18{i_imm[12]}}, i_imm, 1'b0};
endmodule

module jump_unit (
  input  logic [31:0] i_pc,
  input  logic [20:0] i_jal_imm,
  input  logic [11:0] i_jalr_imm,
  input  logic [31:0] i_rs1,
  input  logic        i_jal_enable,
  input  logic        i_jalr_enable,
  output logic        o_taken,
  output logic [31:0] o_target
);
  logic [31:0] w_jal_target;
  logic [31:0] w_jalr_sum;
  assign w_jal_target = i_pc + {{10{i_jal_imm[20]}}, i_jal_imm, 1'b0};
  assign w_jalr_sum   = i_rs1 + {{20{i_jalr_imm[11]}}, i_jalr_imm};
  assign o_taken      = i_jal_enable | i_jalr_enable;
  assign o_target     = i_jal_enable ? w_jal_target : {w_jalr_sum[31:1], 1'b0};
endmodule

module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pc_next,
  output logic [31:0] o_pc
);
  logic [31:0] r_pc;
  always_ff @(posedge clk) r_pc <= reset ? RESET_PC : i_pc_next;
  assign o_pc = r_pc;
endmodule

module pc_control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] imm_raw_branch,
  input  logic        z,
  input  logic        n,
  input  logic        v,
  input  logic        c,
  input  logic [2:0]  func3_branch,
  input  logic        branch_enable,
  input  logic [20:0] jal_imm_raw,
  input  logic [11:0] jalr_imm_raw,
  input  logic [31:0] rs1_value,
  input  logic        jal_enable,
  input  logic        jalr_enable,
  output logic [31:0] pc_current
);
  logic [31:0] w_pc_seq;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_pc_next;
  logic        w_branch_taken;
  logic        w_jump_taken;

  sequential_unit u_seq (
    .i_pc     (pc_current),
    .o_pc_seq (w_pc_seq)
  );

  branch_unit u_branch (
    .i_pc     (pc_current),
    .i_imm    (imm_raw_branch),
    .i_func3  (func3_branch),
    .i_enable (branch_enable),
    .i_z      (z),
    .i_n      (n),
    .i_v      (v),
    .i_c      (c),
    .o_taken  (w_branch_taken),
    .o_target (w_branch_target)
  );

  jump_unit u_jump (
    .i_pc          (pc_current),
    .i_jal_imm     (jal_imm_raw),
    .i_jalr_imm    (jalr_imm_raw),
    .i_rs1         (rs1_value),
    .i_jal_enable  (jal_enable),
    .i_jalr_enable (jalr_enable),
    .o_taken       (w_jump_taken),
    .o_target      (w_jump_target)
  );

  assign w_pc_next = w_jump_taken ? w_jump_target : w_branch_taken ? w_branch_target : w_pc_seq;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .i_pc_next (w_pc_next),
    .o_pc      (pc_current)
  );
endmodule

// File: tb/tb_pc_control_unit.sv
// tb_pc_control_unit: directed next-PC vectors checked against literals and a per-cycle reference model.

module tb_pc_control_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] imm_raw_branch;
  logic        z, n, v, c;
  logic [2:0]  func3_branch;
  logic        branch_enable;
  logic [20:0] jal_imm_raw;
  logic [11:0] jalr_imm_raw;
  logic [31:0] rs1_value;
  logic        jal_enable;
  logic        jalr_enable;
  logic [31:0] pc_current;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_pc = 32'h0;
  logic        model_ok = 1'b0;

  pc_control_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imm_raw_branch (imm_raw_branch),
    .z              (z),
    .n              (n),
    .v              (v),
    .c              (c),
    .func3_branch   (func3_branch),
    .branch_enable  (branch_enable),
    .jal_imm_raw    (jal_imm_raw),
    .jalr_imm_raw   (jalr_imm_raw),
    .rs1_value      (rs1_value),
    .jal_enable     (jal_enable),
    .jalr_enable    (jalr_enable),
    .pc_current     (pc_current)
  );

  always #5 clk = ~clk;

  function automatic logic cond_true();
    case (func3_branch)
      3'b000: return z;
      3'b001: return !z;
      3'b100: return n != v;
      3'b101: return n == v;
      3'b110: return !c;
      3'b111: return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc);
    int off;
    if (jal_enable) begin
      off = $signed(jal_imm_raw);
      return pc + 32'(off * 2);
    end
    if (jalr_enable) begin
      off = $signed(jalr_imm_raw);
      return (rs1_value + 32'(off)) & 32'hFFFF_FFFE;
    end
    if (branch_enable && cond_true()) begin
      off = $signed(imm_raw_branch);
      return pc + 32'(off * 2);
    end
    return pc + 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: pc_current=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      exp_pc   <= 32'h0;
      model_ok <= 1'b1;
    end else if (model_ok) exp_pc <= model_next(exp_pc);
  end

  always @(negedge clk) if (model_ok) check("model", pc_current, exp_pc);

  task automatic clr();
    reset = 0; imm_raw_branch = 0; z = 0; n = 0; v = 0; c = 0; func3_branch = 0;
    branch_enable = 0; jal_imm_raw = 0; jalr_imm_raw = 0; rs1_value = 0;
    jal_enable = 0; jalr_enable = 0;
  endtask

  task automatic step(input string name, input logic [31:0] exp);
    @(posedge clk);
    #1;
    check(name, pc_current, exp);
  endtask

  task automatic br(input logic [2:0] f3, input logic [12:0] imm, input logic [3:0] znvc);
    clr();
    branch_enable = 1; func3_branch = f3; imm_raw_branch = imm;
    {z, n, v, c} = znvc;
  endtask

  initial begin
    clr();
    reset = 1;
    step("reset1", 32'd0);
    step("reset2", 32'd0);
    reset = 0;
    step("seq4", 32'd4);
    step("seq8", 32'd8);
    step("seq12", 32'd12);
    br(3'b000, 13'd4, 4'b1000); step("beq_t", 32'd20);
    br(3'b001, 13'd4, 4'b0000); step("bne_t", 32'd28);
    br(3'b100, 13'd4, 4'b0100); step("blt_t", 32'd36);
    br(3'b101, 13'd4, 4'b0000); step("bge_t", 32'd44);
    br(3'b110, 13'd4, 4'b0000); step("bltu_t", 32'd52);
    br(3'b111, 13'd4, 4'b0001); step("bgeu_t", 32'd60);
    br(3'b000, 13'd4, 4'b0000); step("beq_nt", 32'd64);
    br(3'b001, 13'd4, 4'b1000); step("bne_nt", 32'd68);
    br(3'b010, 13'd4, 4'b1111); step("f010_nt", 32'd72);
    br(3'b000, 13'd4, 4'b1000); branch_enable = 0; step("ben0_nt", 32'd76);
    br(3'b100, 13'd4, 4'b0110); step("blt_nt", 32'd80);
    br(3'b101, 13'd4, 4'b0100); step("bge_nt", 32'd84);
    br(3'b110, 13'd4, 4'b0001); step("bltu_nt", 32'd88);
    br(3'b111, 13'd4, 4'b0000); step("bgeu_nt", 32'd92);
    br(3'b011, 13'd4, 4'b1111); step("f011_nt", 32'd96);
    clr(); jal_enable = 1; jal_imm_raw = 21'd4; step("jal", 32'd104);
    clr(); jalr_enable = 1; rs1_value = 32'd100; jalr_imm_raw = 12'd4; step("jalr", 32'd104);
    clr(); jalr_enable = 1; rs1_value = 32'd101; step("jalr_lsb", 32'd100);
    clr(); jalr_enable = 1; rs1_value = 32'h1000; jalr_imm_raw = 12'hFFF; step("jalr_neg", 32'hFFE);
    br(3'b000, 13'd4, 4'b1000);
    jal_enable = 1; jal_imm_raw = 21'd4; jalr_enable = 1; rs1_value = 32'd500;
    step("prio_jal", 32'hFFE + 32'd8);
    br(3'b000, 13'd4, 4'b1000); jalr_enable = 1; rs1_value = 32'd500;
    step("prio_jalr", 32'd500);
    clr(); reset = 1; step("reset_mid", 32'd0);
    reset = 0; step("r4", 32'd4);
    step("r8", 32'd8);
    br(3'b000, 13'h1FFE, 4'b1000); step("bneg", 32'd4);
    step("bneg0", 32'd0);
    step("bwrap", 32'hFFFF_FFFC);
    clr(); jal_enable = 1; jal_imm_raw = 21'h1FFFFE; step("jal_neg", 32'hFFFF_FFF8);
    clr(); jal_enable = 1; jal_imm_raw = 21'd6; step("jal_wrap", 32'h0000_0004);
    clr(); jalr_enable = 1; rs1_value = 32'hFFFF_FFFF; jalr_imm_raw = 12'd1; step("jalr_wrap", 32'd0);
    clr(); jalr_enable = 1; rs1_value = 32'd200; reset = 1; step("reset_jalr", 32'd0);
    clr(); step("after_reset", 32'd4);
    step("after_reset2", 32'd8);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
